// File: rtl/seq_mult_engine.sv
`default_nettype none
// ============================================================================
// Module  : seq_mult_engine
// Brief   : Radix-2 shift-add unsigned multiplier (a*b or a*CONST), start/done handshake.
// Revision: 1.0
// ============================================================================
module seq_mult_engine #(
  parameter int              WIDTH = 32,
  parameter longint unsigned CONST = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_hi,
  output logic             ovf
);

  localparam int             CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] c_mult = WIDTH'(CONST);
  localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  c_one  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_z;
  logic [WIDTH-1:0]   r_z_hi;
  logic               r_ovf;

  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  // The multiplicand register is pre-shifted each step, so it always holds a << count.
  always_comb begin
    w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    w_last    = (r_cnt == c_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_z      <= '0;
      r_z_hi   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= mode ? c_mult : b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_one;
          if (w_last) begin
            r_z     <= w_acc_nxt[WIDTH-1:0];
            r_z_hi  <= w_acc_nxt[2*WIDTH-1:WIDTH];
            r_ovf   <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign z    = r_z;
  assign z_hi = r_z_hi;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_engine.sv
`default_nettype none
// Self-checking bench for seq_mult_engine: directed table, handshake corner cases,
// reset during RUN and a randomized regression against a plain-arithmetic model.
module tb_seq_mult_engine;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] z;
  logic [W-1:0] z_hi;
  logic         ovf;

  int vectors     = 0;
  int miscompares = 0;
  logic prev_done = 1'b0;

  seq_mult_engine #(.WIDTH(W), .CONST(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .z_hi  (z_hi),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         m;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ez;
    logic [W-1:0] ezhi;
    logic         eovf;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshake invariants observed every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) begin
        miscompares = miscompares + 1;
        $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
      end
      if (done && prev_done) begin
        miscompares = miscompares + 1;
        $display("FAIL done_two_cycles: got done high twice expected single pulse");
      end
    end
    prev_done <= done;
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n = n + 1;
    end while (!done && n < 200);
  endtask

  // Launches one operation; lat is the number of edges from acceptance to done.
  task automatic run_op(input logic m, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [63:0] prod, output logic o, output int lat);
    logic [W-1:0] zbefore;
    int n;
    @(negedge clk);
    mode  = m;
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    zbefore = z;
    repeat (16) @(posedge clk);
    #1;
    check("z_stable_in_run", 64'(z), 64'(zbefore));
    wait_done(n);
    lat  = n + 16;
    prod = {z_hi, z};
    o    = ovf;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prod;
    logic [63:0] exp;
    logic        o;
    int          lat;
    int          n;
    int          n2;
    int          done_cnt;

    tbl[0] = '{1'b1, 32'h55555555, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    tbl[1] = '{1'b1, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFD, 32'h00000002, 1'b1};
    tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    tbl[3] = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
    tbl[4] = '{1'b0, 32'h00000002, 32'h00000003, 32'h00000006, 32'h00000000, 1'b0};
    tbl[5] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1};
    tbl[6] = '{1'b1, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0};
    tbl[7] = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000001, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    check("reset_outputs", {27'b0, busy, done, ovf, |z, |z_hi}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].m, tbl[i].va, tbl[i].vb, prod, o, lat);
      check($sformatf("tbl%0d_z", i),    64'(prod[31:0]),  64'(tbl[i].ez));
      check($sformatf("tbl%0d_zhi", i),  64'(prod[63:32]), 64'(tbl[i].ezhi));
      check($sformatf("tbl%0d_ovf", i),  64'(o),           64'(tbl[i].eovf));
      check($sformatf("tbl%0d_lat", i),  64'(lat),         64'd32);
    end

    // Operands change and start pulses mid-RUN; start held through DONE chains an op.
    @(negedge clk);
    mode = 1'b0; a = 32'd5; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    a = 32'hDEAD0000; b = 32'hBEEF0000; mode = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
    wait_done(n);
    check("b2b_first_lat", 64'(n + 5), 64'd32);
    check("b2b_first_z", {z_hi, z}, 64'd35);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accept_busy", 64'(busy), 64'd1);
    wait_done(n2);
    check("b2b_spacing", 64'(n2 + 1), 64'd33);
    check("b2b_second_z", {z_hi, z}, 64'd143);

    // Reset in the middle of a CONST-mode operation.
    @(negedge clk);
    mode = 1'b1; a = 32'd7; b = 32'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_run_busy", 64'(busy), 64'd0);
    check("rst_run_done", 64'(done), 64'd0);
    check("rst_run_z", {z_hi, z}, 64'd0);
    check("rst_run_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_cnt = done_cnt + 1;
    end
    check("rst_no_done", 64'(done_cnt), 64'd0);
    run_op(1'b1, 32'd7, 32'd0, prod, o, lat);
    check("post_rst_z", prod, 64'd21);

    // Randomized regression against exact arithmetic.
    for (int k = 0; k < 1000; k++) begin
      logic         m;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [63:0]  mult;
      m    = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      mult = m ? 64'd3 : {32'b0, rb};
      exp  = {32'b0, ra} * mult;
      run_op(m, ra, rb, prod, o, lat);
      check($sformatf("rnd%0d_prod a=%h b=%h m=%0d", k, ra, rb, m), prod, exp);
      check($sformatf("rnd%0d_ovf", k), 64'(o), 64'(exp[63:32] != 0));
      check($sformatf("rnd%0d_lat", k), 64'(lat), 64'd32);
      if (prod === exp)
        $display("PASS case %0d a=%h b=%h z=%h expected %h", k, ra, rb, prod, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
